// File: rtl/ale_pkg.sv
// Shared types, widths and helpers for the atmospheric light estimation block.
// Holds the state encoding, the RGB payload struct, the per-channel clamp and
// the elaboration-time reciprocal table builder.
package ale_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned RECIP_W     = 10;
    localparam int unsigned RECIP_SCALE = 1024;
    localparam int unsigned ROM_DEPTH   = 1 << PIX_W;
    localparam int unsigned RECIP_MAX   = (1 << RECIP_W) - 1;
    localparam int unsigned ROM_BITS    = ROM_DEPTH * RECIP_W;
    localparam int unsigned ROM_IDX_W   = $clog2(ROM_BITS);

    typedef enum logic [2:0] {
        ACCUM,
        LUT_R,
        LUT_G,
        LUT_B,
        PUBLISH
    } ale_state_e;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    // Raise each channel to at least a_min.
    function automatic rgb_t clamp_rgb(input rgb_t px, input logic [PIX_W-1:0] a_min);
        rgb_t res;
        res.r = (px.r < a_min) ? a_min : px.r;
        res.g = (px.g < a_min) ? a_min : px.g;
        res.b = (px.b < a_min) ? a_min : px.b;
        return res;
    endfunction

    // Constant table of round(RECIP_SCALE/i), saturated to RECIP_MAX (covers i=0,1).
    function automatic logic [ROM_BITS-1:0] build_recip_table();
        logic [ROM_BITS-1:0] tbl;
        int unsigned         v;
        tbl = '0;
        for (int unsigned i = 0; i < ROM_DEPTH; i++) begin
            if (i < 2) begin
                v = RECIP_MAX;
            end else begin
                v = (RECIP_SCALE + i / 2) / i;
                if (v > RECIP_MAX) v = RECIP_MAX;
            end
            tbl[i*RECIP_W +: RECIP_W] = RECIP_W'(v);
        end
        return tbl;
    endfunction

endpackage

// File: rtl/ale_recip_rom.sv
// Combinational reciprocal ROM: recip_c = round(1024/a_in), saturating to 1023
// for a_in of 0 or 1.
// Ports: a_in (PIX_W) lookup address; recip_c (RECIP_W) table entry.
module ale_recip_rom
    import ale_pkg::*;
(
    input  logic [PIX_W-1:0]   a_in,
    output logic [RECIP_W-1:0] recip_c
);

    localparam logic [ROM_BITS-1:0] RECIP_TABLE = build_recip_table();

    logic [ROM_IDX_W-1:0] idx;

    assign idx     = ROM_IDX_W'(32'(a_in) * RECIP_W);
    assign recip_c = RECIP_TABLE[idx +: RECIP_W];

endmodule

// File: rtl/ale_light_sequencer.sv
// Atmospheric light estimation controller. Tracks the brightest dark-channel
// pixel of each frame, snapshots its clamped RGB at frame end, walks one shared
// reciprocal ROM over R/G/B and publishes A and 1024/A with a one-cycle strobe.
// Ports: clk, rst_n; frame_start/frame_end pulses; pix_valid qualifies
// pix_r/g/b and dc_val; a_r/g/b and inv_a_r/g/b published values; a_update
// publish strobe; a_valid level after first publish; busy outside ACCUM;
// overrun sticky on frame_end while busy.
module ale_light_sequencer
    import ale_pkg::*;
#(
    parameter int unsigned A_MIN = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_r,
    input  logic [PIX_W-1:0]   pix_g,
    input  logic [PIX_W-1:0]   pix_b,
    input  logic [PIX_W-1:0]   dc_val,
    output logic [PIX_W-1:0]   a_r,
    output logic [PIX_W-1:0]   a_g,
    output logic [PIX_W-1:0]   a_b,
    output logic [RECIP_W-1:0] inv_a_r,
    output logic [RECIP_W-1:0] inv_a_g,
    output logic [RECIP_W-1:0] inv_a_b,
    output logic               a_update,
    output logic               a_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [PIX_W-1:0] A_MIN_V = PIX_W'(A_MIN);

    ale_state_e         state_q, state_d;
    logic [PIX_W-1:0]   max_dc_q, max_dc_d;
    rgb_t               cand_q, cand_d;
    rgb_t               snap_q, snap_d;
    logic [RECIP_W-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
    rgb_t               a_q, a_d;
    logic [RECIP_W-1:0] inv_r_q, inv_r_d, inv_g_q, inv_g_d, inv_b_q, inv_b_d;
    logic               a_update_q, a_update_d;
    logic               a_valid_q, a_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic               new_frame_c;
    logic [PIX_W-1:0]   base_dc_c, eff_dc_c;
    rgb_t               base_cand_c, eff_cand_c, pix_c;
    logic               take_c;
    logic [PIX_W-1:0]   rom_in_c;
    logic [RECIP_W-1:0] rom_out_c;

    ale_recip_rom u_recip_rom (
        .a_in    (rom_in_c),
        .recip_c (rom_out_c)
    );

    // State, accumulator, shadow and published registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            max_dc_q   <= '0;
            cand_q     <= '0;
            snap_q     <= '0;
            sh_r_q     <= '0;
            sh_g_q     <= '0;
            sh_b_q     <= '0;
            a_q        <= '0;
            inv_r_q    <= '0;
            inv_g_q    <= '0;
            inv_b_q    <= '0;
            a_update_q <= 1'b0;
            a_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_dc_q   <= max_dc_d;
            cand_q     <= cand_d;
            snap_q     <= snap_d;
            sh_r_q     <= sh_r_d;
            sh_g_q     <= sh_g_d;
            sh_b_q     <= sh_b_d;
            a_q        <= a_d;
            inv_r_q    <= inv_r_d;
            inv_g_q    <= inv_g_d;
            inv_b_q    <= inv_b_d;
            a_update_q <= a_update_d;
            a_valid_q  <= a_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Accumulator update, sequencing and publish.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        sh_r_d     = sh_r_q;
        sh_g_d     = sh_g_q;
        sh_b_d     = sh_b_q;
        a_d        = a_q;
        inv_r_d    = inv_r_q;
        inv_g_d    = inv_g_q;
        inv_b_d    = inv_b_q;
        a_update_d = 1'b0;
        a_valid_d  = a_valid_q;
        overrun_d  = overrun_q;
        rom_in_c   = '0;

        // A lone frame_start pixel competes against a cleared accumulator;
        // with frame_end in the same cycle it still belongs to the old frame.
        pix_c       = {pix_r, pix_g, pix_b};
        new_frame_c = frame_start && !frame_end;
        base_dc_c   = new_frame_c ? '0 : max_dc_q;
        base_cand_c = new_frame_c ? '0 : cand_q;
        take_c      = pix_valid && (dc_val > base_dc_c);
        eff_dc_c    = take_c ? dc_val : base_dc_c;
        eff_cand_c  = take_c ? pix_c  : base_cand_c;

        if (frame_start && frame_end) begin
            max_dc_d = '0;
            cand_d   = '0;
        end else begin
            max_dc_d = eff_dc_c;
            cand_d   = eff_cand_c;
        end

        if (frame_end && (state_q != ACCUM)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ACCUM: begin
                if (frame_end) begin
                    snap_d  = clamp_rgb(eff_cand_c, A_MIN_V);
                    state_d = LUT_R;
                end
            end
            LUT_R: begin
                rom_in_c = snap_q.r;
                sh_r_d   = rom_out_c;
                state_d  = LUT_G;
            end
            LUT_G: begin
                rom_in_c = snap_q.g;
                sh_g_d   = rom_out_c;
                state_d  = LUT_B;
            end
            LUT_B: begin
                rom_in_c = snap_q.b;
                sh_b_d   = rom_out_c;
                state_d  = PUBLISH;
            end
            PUBLISH: begin
                a_d        = snap_q;
                inv_r_d    = sh_r_q;
                inv_g_d    = sh_g_q;
                inv_b_d    = sh_b_q;
                a_update_d = 1'b1;
                a_valid_d  = 1'b1;
                state_d    = ACCUM;
            end
            default: state_d = ACCUM;
        endcase

        busy_d = (state_d != ACCUM);
    end

    assign a_r      = a_q.r;
    assign a_g      = a_q.g;
    assign a_b      = a_q.b;
    assign inv_a_r  = inv_r_q;
    assign inv_a_g  = inv_g_q;
    assign inv_a_b  = inv_b_q;
    assign a_update = a_update_q;
    assign a_valid  = a_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_ale_light_sequencer.sv
// Directed self-checking bench for ale_light_sequencer (A_MIN = 100).
module tb_ale_light_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, frame_end, pix_valid;
    logic [7:0] pix_r, pix_g, pix_b, dc_val;
    logic [7:0] a_r, a_g, a_b;
    logic [9:0] inv_a_r, inv_a_g, inv_a_b;
    logic       a_update, a_valid, busy, overrun;

    int errors = 0;
    int checks = 0;

    ale_light_sequencer #(.A_MIN(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .dc_val      (dc_val),
        .a_r         (a_r),
        .a_g         (a_g),
        .a_b         (a_b),
        .inv_a_r     (inv_a_r),
        .inv_a_g     (inv_a_g),
        .inv_a_b     (inv_a_b),
        .a_update    (a_update),
        .a_valid     (a_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then return them to idle.
    task automatic px(input logic fs, input logic fe, input logic pv,
                      input logic [7:0] dc, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b);
        frame_start = fs; frame_end = fe; pix_valid = pv;
        dc_val = dc; pix_r = r; pix_g = g; pix_b = b;
        cyc();
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
        dc_val = '0; pix_r = '0; pix_g = '0; pix_b = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
        dc_val = '0; pix_r = '0; pix_g = '0; pix_b = '0;
        repeat (3) cyc();
        checks++;
        if ({a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_update, a_valid, busy, overrun} !== 58'd0) begin
            errors++;
            $display("FAIL reset_init: outputs=%h expected 0",
                     {a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_update, a_valid, busy, overrun});
        end
        @(negedge clk) rst_n = 1'b1;
        cyc();
        px(1, 0, 0, 0, 0, 0, 0);
        px(0, 0, 1, 77, 7, 8, 9);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_update, a_valid, busy, overrun} !== 58'd0) begin
            errors++;
            $display("FAIL reset_midframe: outputs=%h expected 0",
                     {a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_update, a_valid, busy, overrun});
        end
        @(negedge clk) rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic_publish();
        px(1, 0, 0, 0, 0, 0, 0);
        px(0, 0, 1, 10, 1, 2, 3);
        px(0, 0, 1, 200, 220, 210, 205);
        px(0, 0, 1, 200, 180, 170, 160);
        px(0, 0, 1, 50, 9, 9, 9);
        px(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b expected 1", busy);
        end
        cyc(); cyc(); cyc();
        checks++;
        if ({a_update, a_valid, a_r} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL basic_early: upd=%b valid=%b a_r=%0d expected 0 0 0", a_update, a_valid, a_r);
        end
        cyc();
        checks++;
        if ({a_update, a_valid} !== 2'b11) begin
            errors++;
            $display("FAIL basic_strobe: upd=%b valid=%b expected 1 1", a_update, a_valid);
        end
        checks++;
        if ({a_r, a_g, a_b} !== {8'd220, 8'd210, 8'd205}) begin
            errors++;
            $display("FAIL basic_a: a=%0d,%0d,%0d expected 220,210,205", a_r, a_g, a_b);
        end
        checks++;
        if ({inv_a_r, inv_a_g, inv_a_b} !== {10'd5, 10'd5, 10'd5}) begin
            errors++;
            $display("FAIL basic_inv: inv=%0d,%0d,%0d expected 5,5,5", inv_a_r, inv_a_g, inv_a_b);
        end
        cyc();
        checks++;
        if ({a_update, busy, a_valid, a_r} !== {1'b0, 1'b0, 1'b1, 8'd220}) begin
            errors++;
            $display("FAIL basic_after: upd=%b busy=%b valid=%b a_r=%0d expected 0 0 1 220",
                     a_update, busy, a_valid, a_r);
        end
    endtask

    task automatic test_clamp();
        px(1, 0, 0, 0, 0, 0, 0);
        px(0, 0, 1, 5, 200, 200, 200);
        px(0, 1, 1, 30, 40, 150, 255);
        cyc(); cyc(); cyc();
        cyc();
        checks++;
        if (a_update !== 1'b1) begin
            errors++;
            $display("FAIL clamp_strobe: upd=%b expected 1", a_update);
        end
        checks++;
        if ({a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b} !== {8'd100, 8'd150, 8'd255, 10'd10, 10'd7, 10'd4}) begin
            errors++;
            $display("FAIL clamp_vals: a=%0d,%0d,%0d inv=%0d,%0d,%0d expected 100,150,255 10,7,4",
                     a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b);
        end
        cyc();
    endtask

    task automatic test_empty_frame();
        px(1, 0, 0, 0, 0, 0, 0);
        cyc();
        px(0, 1, 0, 0, 0, 0, 0);
        cyc(); cyc(); cyc();
        cyc();
        checks++;
        if ({a_update, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b} !==
            {1'b1, 8'd100, 8'd100, 8'd100, 10'd10, 10'd10, 10'd10}) begin
            errors++;
            $display("FAIL empty_vals: upd=%b a=%0d,%0d,%0d inv=%0d,%0d,%0d expected 1 100,100,100 10,10,10",
                     a_update, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b);
        end
        cyc();
    endtask

    task automatic test_same_cycle_overrun();
        int upd_cnt;
        px(1, 0, 0, 0, 0, 0, 0);
        px(0, 0, 1, 20, 5, 5, 5);
        px(1, 1, 1, 255, 250, 250, 250);
        cyc();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pre: overrun=%b expected 0", overrun);
        end
        px(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: overrun=%b expected 1", overrun);
        end
        cyc();
        checks++;
        if (a_update !== 1'b0) begin
            errors++;
            $display("FAIL ovr_early: upd=%b expected 0", a_update);
        end
        cyc();
        checks++;
        if ({a_update, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b} !==
            {1'b1, 8'd250, 8'd250, 8'd250, 10'd4, 10'd4, 10'd4}) begin
            errors++;
            $display("FAIL ovr_vals: upd=%b a=%0d,%0d,%0d inv=%0d,%0d,%0d expected 1 250,250,250 4,4,4",
                     a_update, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b);
        end
        upd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (a_update === 1'b1) upd_cnt++;
        end
        checks++;
        if (upd_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovr_single: extra_updates=%0d busy=%b expected 0 0", upd_cnt, busy);
        end
        // The straddling pixel must not have seeded the new frame.
        px(0, 1, 0, 0, 0, 0, 0);
        cyc(); cyc(); cyc();
        cyc();
        checks++;
        if ({a_update, a_r, a_g, a_b, overrun} !== {1'b1, 8'd100, 8'd100, 8'd100, 1'b1}) begin
            errors++;
            $display("FAIL ovr_newframe: upd=%b a=%0d,%0d,%0d overrun=%b expected 1 100,100,100 1",
                     a_update, a_r, a_g, a_b, overrun);
        end
        cyc();
    endtask

    task automatic test_reset_recovery();
        int upd_cnt;
        px(1, 0, 0, 0, 0, 0, 0);
        px(0, 0, 1, 60, 7, 7, 7);
        px(0, 1, 0, 0, 0, 0, 0);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_update, a_valid, busy, overrun} !== 58'd0) begin
            errors++;
            $display("FAIL rec_reset: outputs=%h expected 0",
                     {a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_update, a_valid, busy, overrun});
        end
        @(negedge clk) rst_n = 1'b1;
        upd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (a_update === 1'b1) upd_cnt++;
        end
        checks++;
        if (upd_cnt !== 0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL rec_abort: updates=%0d valid=%b expected 0 0", upd_cnt, a_valid);
        end
        px(1, 0, 0, 0, 0, 0, 0);
        px(0, 0, 1, 90, 128, 64, 200);
        px(0, 1, 0, 0, 0, 0, 0);
        cyc(); cyc(); cyc();
        cyc();
        checks++;
        if ({a_update, a_valid, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b} !==
            {1'b1, 1'b1, 8'd128, 8'd100, 8'd200, 10'd8, 10'd10, 10'd5}) begin
            errors++;
            $display("FAIL rec_publish: upd=%b valid=%b a=%0d,%0d,%0d inv=%0d,%0d,%0d expected 1 1 128,100,200 8,10,5",
                     a_update, a_valid, a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic_publish();
        test_clamp();
        test_empty_frame();
        test_same_cycle_overrun();
        test_reset_recovery();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
